// File: rtl/cam_pkg.sv
// Shared types and defaults for the camera pixel capture block.
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    ACTIVE  = 2'd2,
    SKIP    = 2'd3
  } cam_state_t;

  localparam int CAM_BYTE_W          = 8;
  localparam int CAM_BYTES_PER_PIXEL = 2;

  // OV7670 RGB565 VGA defaults
  localparam int RGB565_BYTES_PER_PIXEL = 2;
  localparam int RGB565_X_MIN           = 0;
  localparam int RGB565_X_MAX           = 639;
  localparam int RGB565_Y_MIN           = 0;
  localparam int RGB565_Y_MAX           = 479;

endpackage

// File: rtl/cam_sync_edge.sv
// STAGES-deep synchroniser for one asynchronous bit, with rise/fall strobes on the synchronised value.
module cam_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sr;
  logic              q_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      q_d <= 1'b0;
    end else begin
      sr  <= {sr[STAGES-2:0], din};
      q_d <= sr[STAGES-1];
    end
  end

  assign q    = sr[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/cam_pixel_capture.sv
// Oversampled OV7670-style capture: byte assembly, crop window, frame decimation, valid/ready output.
// Define CAM_CAPTURE_STATS_EN to add the frame_count / drop_count outputs.
module cam_pixel_capture
  import cam_pkg::*;
#(
  parameter  int BYTE_W          = CAM_BYTE_W,
  parameter  int BYTES_PER_PIXEL = CAM_BYTES_PER_PIXEL,
  parameter  int X_W             = 11,
  parameter  int Y_W             = 10,
  parameter  int SYNC_STAGES     = 2,
  localparam int DATA_W          = BYTE_W * BYTES_PER_PIXEL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              cmos_pclk,
  input  logic              cmos_href,
  input  logic              cmos_vsync,
  input  logic [BYTE_W-1:0] cmos_db,
  input  logic [X_W-1:0]    crop_x0,
  input  logic [X_W-1:0]    crop_x1,
  input  logic [Y_W-1:0]    crop_y0,
  input  logic [Y_W-1:0]    crop_y1,
  input  logic [3:0]        frame_skip,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eol,
  output logic              overflow,
  input  logic              clr_overflow,
  output logic              busy
`ifdef CAM_CAPTURE_STATS_EN
  ,
  output logic [15:0]       frame_count,
  output logic [15:0]       drop_count
`endif
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_PIXEL - 1);

  cam_state_t state, state_nx;

  logic pclk_rise, href_s, hr_fall, vs_rise, vs_fall;
  logic pclk_s_unused, pclk_fall_unused, href_rise_unused, vsync_s_unused;
  logic [SYNC_STAGES-1:0][BYTE_W-1:0] db_sr;
  logic [BYTE_W-1:0] db_s;

  logic [X_W-1:0]    x, cx0, cx1;
  logic [Y_W-1:0]    y, cy0, cy1;
  logic [1:0]        byte_cnt;
  logic [3:0]        skip_cnt;
  logic [DATA_W-1:0] asm_q, asm_nx;
  logic              sof_pend;
  logic frame_start, enter_active, take, pix_done, in_win, emit, load, drop;

  cam_sync_edge #(.STAGES(SYNC_STAGES)) u_pclk (
    .clk(clk), .rst(rst), .din(cmos_pclk),
    .q(pclk_s_unused), .rise(pclk_rise), .fall(pclk_fall_unused));
  cam_sync_edge #(.STAGES(SYNC_STAGES)) u_href (
    .clk(clk), .rst(rst), .din(cmos_href),
    .q(href_s), .rise(href_rise_unused), .fall(hr_fall));
  cam_sync_edge #(.STAGES(SYNC_STAGES)) u_vsync (
    .clk(clk), .rst(rst), .din(cmos_vsync),
    .q(vsync_s_unused), .rise(vs_rise), .fall(vs_fall));

  // Data bus gets the same depth as the strobes so a byte lines up with its pclk edge
  always_ff @(posedge clk) begin
    if (rst) db_sr <= '0;
    else     db_sr <= {db_sr[SYNC_STAGES-2:0], cmos_db};
  end
  assign db_s = db_sr[SYNC_STAGES-1];

  always_comb begin
    state_nx     = state;
    frame_start  = 1'b0;
    enter_active = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nx = WAIT_VS;
        WAIT_VS: if (vs_fall) begin
          frame_start  = 1'b1;
          enter_active = (skip_cnt == 4'd0);
          state_nx     = enter_active ? ACTIVE : SKIP;
        end
        ACTIVE, SKIP: if (vs_rise) state_nx = WAIT_VS;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    asm_nx   = DATA_W'({asm_q, db_s});
    take     = (state == ACTIVE) && !vs_rise && pclk_rise && href_s;
    pix_done = take && (byte_cnt == LAST_BYTE);
    in_win   = (x >= cx0) && (x <= cx1) && (y >= cy0) && (y <= cy1);
    emit     = pix_done && in_win;
    load     = emit && (!out_valid || out_ready);
    drop     = emit && out_valid && !out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      byte_cnt  <= '0;
      skip_cnt  <= '0;
      cx0       <= '0;
      cx1       <= '0;
      cy0       <= '0;
      cy1       <= '0;
      asm_q     <= '0;
      sof_pend  <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nx;

      if (frame_start) begin
        cx0      <= crop_x0;
        cx1      <= crop_x1;
        cy0      <= crop_y0;
        cy1      <= crop_y1;
        x        <= '0;
        y        <= '0;
        byte_cnt <= '0;
        skip_cnt <= (skip_cnt == 4'd0) ? frame_skip : skip_cnt - 4'd1;
        if (enter_active) sof_pend <= 1'b1;
      end

      if (state == ACTIVE) begin
        if (vs_rise) begin
          byte_cnt <= '0;
        end else if (hr_fall) begin
          // A line that produced no complete pixel does not advance y
          byte_cnt <= '0;
          x        <= '0;
          if (x != '0 && y != '1) y <= y + 1'b1;
        end else if (take) begin
          asm_q <= asm_nx;
          if (pix_done) begin
            byte_cnt <= '0;
            if (x != '1) x <= x + 1'b1;
          end else begin
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
      end

      if (load) begin
        out_data  <= asm_nx;
        out_valid <= 1'b1;
        out_sof   <= sof_pend;
        out_eol   <= (x == cx1);
        sof_pend  <= 1'b0;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_sof   <= 1'b0;
        out_eol   <= 1'b0;
      end

      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  assign busy = (state == ACTIVE) || (state == SKIP);

`ifdef CAM_CAPTURE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      if (enter_active) frame_count <= frame_count + 16'd1;
      if (drop) begin
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end else if (clr_overflow) begin
        drop_count <= '0;
      end
    end
  end
`endif

endmodule
